// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // LSB position of field k in a flattened bus of w-bit fields
    function automatic int fld_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: allocation sets, writeback clears, allocation wins a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    rd_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy state; allocation is applied after clears so the new producer wins
    always_comb begin
        busy_d = busy_q;
        if (run_i) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p]) begin
                    busy_d[wr_addr_i[fld_lsb(p, AW) +: AW]] = 1'b0;
                end else begin
                    busy_d = busy_d;
                end
            end
            if (alloc_en_i) begin
                busy_d[alloc_addr_i] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end else begin
            busy_d = busy_q;
        end
        busy_d[0] = 1'b0;
    end

    // Busy bit storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= {NREG{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered busy lookup per read port, forced low while clearing
    always_comb begin
        rd_busy_o = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (run_i) begin
                rd_busy_o[k] = busy_q[rd_addr_i[fld_lsb(k, AW) +: AW]];
            end else begin
                rd_busy_o[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// post-reset clear sequencer and issue-stage busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD*XLEN-1:0] rd_data_q,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                ready
);

    state_e              state_q;
    logic [AW-1:0]       clr_idx_q;
    logic                ready_q;
    logic [XLEN-1:0]     mem_q [NREG];
    logic [XLEN-1:0]     mem_d [NREG];
    logic [NRD*XLEN-1:0] rd_data_s;
    logic                run_s;

    assign run_s   = (state_q == ST_RUN);
    assign ready   = ready_q;
    assign rd_data = rd_data_s;

    // Clear sequencer: one entry per cycle, then RUN until the next reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= {AW{1'b0}};
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ready_q <= 1'b0;
                    if (clr_idx_q == AW'(NREG - 1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_idx_q <= {AW{1'b0}};
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Array next state; ascending port loop lets the highest index win
    always_comb begin
        mem_d = mem_q;
        if (!run_s) begin
            mem_d[clr_idx_q] = {XLEN{1'b0}};
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[fld_lsb(p, AW) +: AW] != {AW{1'b0}})) begin
                    mem_d[wr_addr[fld_lsb(p, AW) +: AW]] = wr_data[fld_lsb(p, XLEN) +: XLEN];
                end else begin
                    mem_d = mem_d;
                end
            end
        end
    end

    // Array storage; contents are defined by the clear sequence, not by reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read ports with same-cycle bypass, disabled while clearing
    always_comb begin
        rd_data_s = {(NRD * XLEN){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[fld_lsb(k, AW) +: AW] == {AW{1'b0}}) begin
                rd_data_s[fld_lsb(k, XLEN) +: XLEN] = {XLEN{1'b0}};
            end else begin
                rd_data_s[fld_lsb(k, XLEN) +: XLEN] = mem_q[rd_addr[fld_lsb(k, AW) +: AW]];
                for (int p = 0; p < NWR; p++) begin
                    if (run_s && wr_en[p] &&
                        (wr_addr[fld_lsb(p, AW) +: AW] == rd_addr[fld_lsb(k, AW) +: AW])) begin
                        rd_data_s[fld_lsb(k, XLEN) +: XLEN] = wr_data[fld_lsb(p, XLEN) +: XLEN];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        end
    end

    // Registered copy of the read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= {(NRD * XLEN){1'b0}};
        end else begin
            rd_data_q <= rd_data_s;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_s),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .rd_addr_i    (rd_addr),
        .rd_busy_o    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                ready;

    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];
    logic [XLEN-1:0] exp_rd [NRD];
    logic [XLEN-1:0] exp_q  [NRD];
    bit              q_valid;
    int              n_vec;
    int              n_err;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_data_q  (rd_data_q),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ready      (ready)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_addr[p*AW +: AW]     = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle_in();
        wr_en    = 2'b00;
        alloc_en = 1'b0;
    endtask

    // One RUN-mode cycle: check outputs mid-cycle, then advance the model on the edge
    task automatic run_cycle();
        int a;
        #3;
        for (int k = 0; k < NRD; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            exp_rd[k] = (a == 0) ? 32'h0 : m_mem[a];
            if (a != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a)
                        exp_rd[k] = wr_data[p*XLEN +: XLEN];
                end
            end
            check_eq($sformatf("rd_data[%0d] x%0d", k, a), rd_data[k*XLEN +: XLEN], exp_rd[k]);
            check_eq($sformatf("rd_busy[%0d] x%0d", k, a), 32'(rd_busy[k]), m_busy[a] ? 32'd1 : 32'd0);
            if (q_valid)
                check_eq($sformatf("rd_data_q[%0d]", k), rd_data_q[k*XLEN +: XLEN], exp_q[k]);
        end
        check_eq("ready run", 32'(ready), 32'd1);
        @(posedge clk);
        for (int p = 0; p < NWR; p++) begin
            a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && a != 0) begin
                m_mem[a]  = wr_data[p*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 5'd0)
            m_busy[int'(alloc_addr)] = 1'b1;
        for (int k = 0; k < NRD; k++) exp_q[k] = exp_rd[k];
        q_valid = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        q_valid = 1'b0;
        rst = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        alloc_addr = 5'd0;
        idle_in();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset ready", 32'(ready), 32'd0);
        check_eq("reset rd_data_q", rd_data_q[31:0], 32'h0);

        // Partial clear, then reset again at cycle 10
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("ready partial clear c%0d", i), 32'(ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("ready mid-clear reset", 32'(ready), 32'd0);
        check_eq("rd_data_q mid-clear reset", rd_data_q[63:32], 32'h0);

        // Full clear with writes and allocations to x3 that must be ignored
        @(negedge clk) rst = 1'b1;
        set_wr(0, 3, 32'h0000_1234);
        wr_en = 2'b01;
        alloc_en = 1'b1;
        alloc_addr = 5'd3;
        set_rd(0, 3);
        set_rd(1, 0);
        for (int i = 1; i <= NREG + 1; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("ready clear c%0d", i), 32'(ready), (i == NREG + 1) ? 32'd1 : 32'd0);
            #2;
            check_eq($sformatf("rd_busy clear c%0d", i), 32'(rd_busy), 32'd0);
            check_eq($sformatf("x0 clear c%0d", i), rd_data[63:32], 32'h0);
            if (i >= 4 && i < NREG)
                check_eq($sformatf("x3 no bypass c%0d", i), rd_data[31:0], 32'h0);
            if (i == NREG - 1) idle_in();
        end

        for (int a = 0; a < NREG; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            run_cycle();
        end

        // Write x5 with same-cycle read
        set_wr(0, 5, 32'hDEAD_BEEF);
        wr_en = 2'b01;
        set_rd(0, 5);
        set_rd(1, 5);
        run_cycle();
        idle_in();
        #1;
        check_eq("x5 array", rd_data[31:0], 32'hDEAD_BEEF);
        check_eq("x5 rd_data_q", rd_data_q[31:0], 32'hDEAD_BEEF);
        run_cycle();

        // Dual write to x7
        set_wr(0, 7, 32'h1111_1111);
        set_wr(1, 7, 32'h2222_2222);
        wr_en = 2'b11;
        set_rd(0, 7);
        run_cycle();
        idle_in();
        #1;
        check_eq("x7 dual write", rd_data[31:0], 32'h2222_2222);

        // Register 0 ignores writes and allocations
        set_wr(0, 0, 32'hFFFF_FFFF);
        wr_en = 2'b01;
        alloc_en = 1'b1;
        alloc_addr = 5'd0;
        set_rd(0, 0);
        set_rd(1, 0);
        run_cycle();
        idle_in();
        #1;
        check_eq("x0 data", rd_data[31:0], 32'h0);
        check_eq("x0 busy", 32'(rd_busy[0]), 32'd0);

        // Scoreboard on x9
        set_rd(0, 9);
        alloc_en = 1'b1;
        alloc_addr = 5'd9;
        run_cycle();
        idle_in();
        #1;
        check_eq("x9 busy after alloc", 32'(rd_busy[0]), 32'd1);
        set_wr(1, 9, 32'h0000_0099);
        wr_en = 2'b10;
        run_cycle();
        idle_in();
        #1;
        check_eq("x9 busy after write", 32'(rd_busy[0]), 32'd0);
        wr_en = 2'b01;
        set_wr(0, 9, 32'h0000_0999);
        alloc_en = 1'b1;
        alloc_addr = 5'd9;
        run_cycle();
        idle_in();
        #1;
        check_eq("x9 busy alloc+write", 32'(rd_busy[0]), 32'd1);

        set_rd(1, 3);
        #1;
        check_eq("x3 after clear", rd_data[63:32], 32'h0);
        run_cycle();

        // Random traffic; small address pool half the time to force collisions
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NWR; p++)
                set_wr(p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NREG - 1), $urandom);
            for (int k = 0; k < NRD; k++)
                set_rd(k, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NREG - 1));
            wr_en = NWR'($urandom_range(0, 3));
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, 7));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

- Parametrised multi-port integer register file; successor to the single-write, two-read core register file.
- Adds the following:
  - configurable width, depth, read-port and write-port count;
  - posedge writes with same-cycle write-to-read bypass;
  - hardware clear sequencer after reset;
  - per-register busy scoreboard for the issue stage.
- Sits between decode/issue (read ports, allocation) and writeback (write ports).

## Interface

Parameters:
- XLEN, 32, data width
- NREG, 32, register count (power of two, ≥2)
- NRD, 2, read ports
- NWR, 2, write ports
- AW, $clog2(NREG), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  combinational read data with bypass
- rd_data_q  out  NRD*XLEN  rd_data registered on clk
- rd_busy  out  NRD  scoreboard bit of each rd_addr, combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr busy (producer issued)
- alloc_addr  in  AW  destination being allocated
- ready  out  1  clear sequence finished; array valid

## Operation

- FSM states: CLEAR, RUN.
  - rst low: state=CLEAR, clr_idx=0, ready=0, rd_data_q=0, all busy bits=0, asynchronously.
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx++.
  - CLEAR → RUN: after writing entry NREG-1; ready=1 from the following cycle.
  - RUN: holds until the next reset.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR at index 0.
- In CLEAR:
  - wr_en and alloc_en are ignored;
  - rd_data returns array contents, bypass disabled;
  - rd_busy=0.
- Register 0:
  - always reads 0;
  - writes to it are dropped;
  - never busy; alloc to it is ignored.
- Writes (RUN): each port with wr_en=1 and nonzero wr_addr updates the array on the rising edge.
  - Two ports to the same address in one cycle: highest port index wins.
  - Each accepted write clears the busy bit of its address.
- Bypass: if any wr_en targets a nonzero rd_addr in the same cycle, rd_data is that port's wr_data (highest index wins); otherwise it is the array contents.
- Scoreboard:
  - alloc_en sets busy[alloc_addr].
  - Allocation and write to the same address in the same cycle: busy stays set (the new producer wins).
  - rd_busy[k] reflects the registered bit, not same-cycle writes or allocations.
- Widths: no arithmetic except clr_idx (AW bits, stops at NREG-1, no wrap).

## Timing

- rd_data: zero-cycle latency from rd_addr, wr_en, wr_addr and wr_data.
- rd_data_q: one cycle after rd_data, including bypassed values.
- Written value is visible from the array one cycle after the write edge.
- Busy bit:
  - set on the edge of alloc_en; visible on rd_busy the next cycle;
  - cleared on the write edge; visible the next cycle.
- Clear sequence: exactly NREG cycles after rst deasserts; ready rises on cycle NREG+1 relative to the first clk edge with rst high.

## Structure

- Package regfile_pkg holds:
  - state enum (CLEAR, RUN);
  - default XLEN/NREG constants;
  - helper function for port-field slicing.
- Sub-module regfile_scoreboard (NREG busy bits, alloc/clear priority, NRD lookups).
- Array, bypass and FSM stay in regfile_mp.

## Test plan

- Reset release, NREG=32:
  - ready=0 for 32 cycles, then 1;
  - all rd_data=0;
  - assert rst mid-clear at cycle 10 → ready stays 0 and the clear restarts at index 0.
- Write-then-read:
  - write x5=0xDEADBEEF on port 0, reading x5 in the same cycle → rd_data=0xDEADBEEF at once;
  - rd_data_q=0xDEADBEEF next cycle;
  - array returns 0xDEADBEEF thereafter.
- Dual write to x7: port 0 writes 0x11111111, port 1 writes 0x22222222 in the same cycle → x7=0x22222222.
- Register 0: write x0=0xFFFFFFFF, alloc x0 → rd_data=0, rd_busy=0.
- Scoreboard on x9:
  - alloc x9 → rd_busy=1 next cycle;
  - write x9 → rd_busy=0 next cycle;
  - alloc and write x9 in the same cycle → rd_busy stays 1.
- Writes during CLEAR: wr_en to x3 with 0x1234 → x3 reads 0 after ready.
